mult_sched: RTL and testbench
=============================

# mult_sched

Round-robin scheduler that shares one sequential shift-and-add multiplier among R requesters. Each requester hands over an operand pair with a valid/ready handshake. The block issues one job at a time to the multiplier, waits for `finish`, and returns the tagged 2N-bit product on a single response channel. A watchdog recovers a hung multiplier. The block sits between the requesting units and the multiplier instance, and owns that instance's `start`/`reset` pins.

## Interface
- `N`, 32 — operand width; the product is 2N bits.
- `R`, 4 — number of requesters (2..8); the ID width is `IW = $clog2(R)`.
- `WDOG`, 4*N+16 — watchdog limit, in cycles spent in WAIT.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  R  per-requester job valid.
- `req_ready`  out  R  one-hot grant; transfer when `req_valid[i] & req_ready[i]`.
- `req_a`, `req_b`  in  R*N  packed operands; requester i occupies bits `[i*N +: N]`.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  IW  requester index of the result.
- `resp_o`  out  2N  product.
- `resp_err`  out  1  job aborted by the watchdog; `resp_o` is 0 when set.
- `mult_start`  out  1  one-cycle start pulse to the multiplier.
- `mult_reset`  out  1  multiplier reset: `reset` OR the watchdog pulse.
- `mult_a`, `mult_b`  out  N  latched operands, held stable from ISSUE through WAIT.
- `mult_o`  in  2N  multiplier product.
- `mult_finish`  in  1  multiplier done level.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The winner is the first asserted `req_valid` at or after the rr pointer, searching upward with wrap.
  - `req_ready[winner]` is driven combinationally; every other ready bit is 0.
  - On transfer: latch a, b and id, then go to ISSUE. With no valid, stay in IDLE.
- ISSUE: `mult_start`=1 for exactly this cycle. Load guard=2 and wdog=0, then go to WAIT.
- WAIT:
  - guard decrements to 0. While guard≠0, `mult_finish` is ignored, because the multiplier's finish is stale for its first cycles after start.
  - When guard==0 and `mult_finish`=1: capture `mult_o` into the result register, set err=0, go to RESP.
  - When wdog reaches WDOG-1 without finish: assert `mult_reset` for 1 cycle, set err=1 and result=0, go to RESP.
- RESP:
  - `resp_valid`=1; `resp_o`, `resp_id` and `resp_err` are held stable.
  - On `resp_ready`: rr pointer = (id+1) mod R, go to IDLE.
- Only one job is in flight at a time, and `req_ready` is 0 in every state except IDLE.
- A requester that drops `req_valid` before it is granted loses nothing; no state is kept per requester.
- The rr pointer advances only on a completed response, whether err or not. A requester that holds valid is granted within R jobs.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, rr pointer=0.
  - `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_o`=0, `resp_err`=0.
  - `mult_start`=0, `mult_a`=`mult_b`=0, `mult_reset`=1 while reset is held.
- Reset in any state abandons the job in flight; no response is produced for it.
- Accept at cycle t → `mult_start` at t+1 → WAIT from t+2.
  - Nominal `resp_valid` arrives at ≤ t+4N+8 with the team multiplier.
  - The watchdog abort produces `resp_valid` at t+2+WDOG.
- RESP lasts 1 cycle if `resp_ready` is already high; otherwise it holds indefinitely and no new grant is made.
- Minimum gap from `resp_valid` to the next `req_ready`: the cycle after the response transfer.
- Arithmetic: the product is the full unsigned 2N bits, with no truncation. `resp_o` equals `mult_o` as sampled at the finish cycle.
- Back-pressure never corrupts data: result registers load only in WAIT.

## Test plan
- N=8, R=4, single requester 2: a=13, b=11 → `req_ready[2]` on the first cycle; `resp_valid` with `resp_id`=2, `resp_o`=143, `resp_err`=0 within 4N+8 cycles.
- All four requesters valid continuously, each with a distinct pair (255×255, 0×77, 1×200, 128×2) → grants in order 0,1,2,3,0; products 65025, 0, 200, 256.
- `resp_ready` held low for 20 cycles in RESP → `resp_valid` and data stay stable, `req_ready` stays all 0; a single transfer occurs on release.
- Multiplier model never raises finish → `mult_reset` pulses at WAIT cycle WDOG-1; response has `resp_err`=1, `resp_o`=0; the next job completes normally.
- `reset` asserted mid-WAIT for 3 cycles → all outputs go to their reset values immediately and no response appears; after release, requester 0 is granted first.
- Stale finish: the multiplier model keeps `mult_finish` high from the previous job for 1 cycle after start → that value is not captured; the correct new product is returned.

Source files
------------

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - round-robin scheduler sharing one sequential multiplier among R requesters
module mult_sched #(
    parameter int N    = 32,
    parameter int R    = 4,
    parameter int WDOG = 4*N+16,
    localparam int IW  = $clog2(R)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [R*N-1:0]   req_a,
    input  logic [R*N-1:0]   req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IW-1:0]    resp_id,
    output logic [2*N-1:0]   resp_o,
    output logic             resp_err,
    output logic             mult_start,
    output logic             mult_reset,
    output logic [N-1:0]     mult_a,
    output logic [N-1:0]     mult_b,
    input  logic [2*N-1:0]   mult_o,
    input  logic             mult_finish
);

    localparam int WW = $clog2(WDOG);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG - 1);
    localparam logic [IW:0]   R_W       = (IW+1)'(R);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   id_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [1:0]      guard;
    logic [WW-1:0]   wdog;
    logic [2*N-1:0]  result;
    logic            err;
    logic            start_q;
    logic            resp_q;

    logic [R-1:0]    grant;
    logic [IW-1:0]   win_id;
    logic            found;
    logic [IW:0]     cand;
    logic [IW:0]     rr_next;
    logic            finish_ok;
    logic            wdog_fire;

    // Rotating priority search: first valid requester at or after rr, wrapping at R.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int k = 0; k < R; k++) begin
            cand = {1'b0, rr} + (IW+1)'(k);
            if (cand >= R_W)
                cand = cand - R_W;
            if (!found && req_valid[cand[IW-1:0]]) begin
                found  = 1'b1;
                win_id = cand[IW-1:0];
            end
        end
        grant = found ? (R'(1) << win_id) : '0;
    end

    always_comb begin
        rr_next = {1'b0, id_q} + (IW+1)'(1);
        if (rr_next >= R_W)
            rr_next = '0;
    end

    // The multiplier's finish level is stale just after start, so the guard masks it.
    assign finish_ok = (guard == 2'd0) && mult_finish;
    assign wdog_fire = (state == WAIT) && !finish_ok && (wdog == WDOG_LAST);

    assign req_ready  = (state == IDLE && !reset) ? grant : '0;
    assign mult_reset = reset | wdog_fire;
    assign mult_start = start_q;
    assign mult_a     = a_q;
    assign mult_b     = b_q;
    assign resp_valid = resp_q;
    assign resp_id    = id_q;
    assign resp_o     = result;
    assign resp_err   = err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rr      <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            guard   <= '0;
            wdog    <= '0;
            result  <= '0;
            err     <= 1'b0;
            start_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        a_q     <= req_a[win_id*N +: N];
                        b_q     <= req_b[win_id*N +: N];
                        id_q    <= win_id;
                        start_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    guard <= 2'd2;
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (guard != 2'd0)
                        guard <= guard - 2'd1;
                    if (finish_ok) begin
                        result <= mult_o;
                        err    <= 1'b0;
                        resp_q <= 1'b1;
                        state  <= RESP;
                    end else if (wdog == WDOG_LAST) begin
                        result <= '0;
                        err    <= 1'b1;
                        resp_q <= 1'b1;
                        state  <= RESP;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_q <= 1'b0;
                        rr     <= rr_next[IW-1:0];
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - randomized and directed bench for mult_sched against a job-level model
module tb_mult_sched;

    localparam int N    = 8;
    localparam int R    = 4;
    localparam int WDOG = 4*N+16;

    logic          clk = 1'b0;
    logic          reset;
    logic [R-1:0]  req_valid;
    logic [R-1:0]  req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_id;
    logic [2*N-1:0] resp_o;
    logic          resp_err;
    logic          mult_start;
    logic          mult_reset;
    logic [N-1:0]  mult_a;
    logic [N-1:0]  mult_b;
    logic [2*N-1:0] mult_o;
    logic          mult_finish;

    mult_sched #(.N(N), .R(R), .WDOG(WDOG)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_o(resp_o), .resp_err(resp_err),
        .mult_start(mult_start), .mult_reset(mult_reset),
        .mult_a(mult_a), .mult_b(mult_b),
        .mult_o(mult_o), .mult_finish(mult_finish)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: finish after m_lat cycles, or never (hang), optionally stale.
    int          m_lat;
    bit          m_hang;
    bit          m_stale;
    int          m_cnt;
    bit          m_busy;
    logic [15:0] m_pend;
    logic        m_fin;
    logic [15:0] m_out;

    assign mult_o      = m_out;
    assign mult_finish = m_fin;

    always @(posedge clk) begin
        if (mult_reset) begin
            m_fin  <= 1'b0;
            m_busy <= 1'b0;
            m_out  <= '0;
            m_cnt  <= 0;
        end else if (mult_start) begin
            m_busy <= 1'b1;
            m_cnt  <= m_lat;
            m_pend <= mult_a * mult_b;
            if (!m_stale)
                m_fin <= 1'b0;
        end else if (m_busy) begin
            m_fin <= 1'b0;
            if (!m_hang) begin
                if (m_cnt == 0) begin
                    m_fin  <= 1'b1;
                    m_out  <= m_pend;
                    m_busy <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int model_rr = 0;
    logic [7:0] op_a [R];
    logic [7:0] op_b [R];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_ops();
        for (int i = 0; i < R; i++) begin
            req_a[i*N +: N] = op_a[i];
            req_b[i*N +: N] = op_b[i];
        end
    endtask

    function automatic int pick(input logic [3:0] mask, input int rrp);
        for (int k = 0; k < R; k++)
            if (mask[(rrp + k) % R]) return (rrp + k) % R;
        return -1;
    endfunction

    task automatic run_job(input logic [3:0] mask, input bit keep, input bit hang, input int hold);
        int exp_id;
        int k;
        int rst_at;
        int exp_k;
        logic [15:0] exp_p;
        load_ops();
        req_valid = mask;
        m_hang = hang;
        #1;
        exp_id = pick(mask, model_rr);
        k = 0;
        while (req_ready == '0 && k < 10) begin
            @(negedge clk); #1; k++;
        end
        chk("grant_wait", k, 0);
        chk("grant", req_ready, 4'b0001 << exp_id);
        exp_p = 16'(int'(op_a[exp_id]) * int'(op_b[exp_id]));
        @(negedge clk); #1;
        if (!keep) req_valid = '0;
        chk("start", mult_start, 1);
        chk("mult_a", mult_a, op_a[exp_id]);
        chk("mult_b", mult_b, op_b[exp_id]);
        k = 1;
        rst_at = -1;
        while (!resp_valid && k < WDOG + 10) begin
            @(negedge clk); #1; k++;
            if (mult_reset && rst_at < 0) rst_at = k;
            if (k == 2) chk("start_once", mult_start, 0);
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_id", resp_id, exp_id);
        if (hang) begin
            chk("wdog_latency", k, 2 + WDOG);
            chk("mreset_cycle", rst_at, WDOG + 1);
            chk("err", resp_err, 1);
            chk("resp_o_err", resp_o, 0);
        end else begin
            exp_k = ((m_lat + 3 > 4) ? m_lat + 3 : 4) + 1;
            chk("latency", k, exp_k);
            chk("no_mreset", rst_at, -1);
            chk("err", resp_err, 0);
            chk("product", resp_o, exp_p);
        end
        chk("ready_in_resp", req_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_o", resp_o, hang ? 16'h0 : exp_p);
            chk("hold_id", resp_id, exp_id);
            chk("hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_done", resp_valid, 0);
        model_rr = (exp_id + 1) % R;
        m_hang = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_o", resp_o, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_start", mult_start, 0);
        chk("rst_a", mult_a, 0);
        chk("rst_b", mult_b, 0);
        chk("rst_mreset", mult_reset, 1);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 4'b1111;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        m_lat = 4; m_hang = 1'b0; m_stale = 1'b0;
        for (int i = 0; i < R; i++) begin op_a[i] = 8'd0; op_b[i] = 8'd0; end
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        req_valid = '0;
        @(negedge clk); #1;

        // single requester 2: 13 x 11
        op_a[2] = 8'd13; op_b[2] = 8'd11; m_lat = 10;
        run_job(4'b0100, 1'b0, 1'b0, 0);

        // fresh rr, all four continuously valid
        reset = 1'b1; @(negedge clk); #1; reset = 1'b0; model_rr = 0;
        op_a[0] = 8'd255; op_b[0] = 8'd255;
        op_a[1] = 8'd0;   op_b[1] = 8'd77;
        op_a[2] = 8'd1;   op_b[2] = 8'd200;
        op_a[3] = 8'd128; op_b[3] = 8'd2;
        for (int j = 0; j < 5; j++) begin
            m_lat = j * 3;
            run_job(4'b1111, 1'b1, 1'b0, 0);
        end
        req_valid = '0;

        // back-pressure in RESP for 20 cycles
        op_a[1] = 8'd97; op_b[1] = 8'd233; m_lat = 2;
        run_job(4'b0010, 1'b0, 1'b0, 20);

        // hung multiplier then a normal job
        op_a[3] = 8'd45; op_b[3] = 8'd6;
        run_job(4'b1000, 1'b0, 1'b1, 2);
        op_a[0] = 8'd200; op_b[0] = 8'd199; m_lat = 7;
        run_job(4'b0001, 1'b0, 1'b0, 0);

        // reset mid-WAIT; rr is 1 here, job for requester 2 is abandoned
        op_a[2] = 8'd17; op_b[2] = 8'd3;
        load_ops();
        req_valid = 4'b0100;
        m_lat = 12;
        @(negedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("rst_hold_valid", resp_valid, 0);
            chk("rst_hold_mreset", mult_reset, 1);
        end
        reset = 1'b0;
        model_rr = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("no_resp_after_rst", resp_valid, 0);
        end
        op_a[0] = 8'd9; op_b[0] = 8'd9; m_lat = 3;
        op_a[1] = 8'd5; op_b[1] = 8'd5;
        run_job(4'b1111, 1'b0, 1'b0, 0);

        // stale finish from previous job held one cycle past start
        op_a[1] = 8'd3; op_b[1] = 8'd4; m_lat = 1;
        run_job(4'b0010, 1'b0, 1'b0, 0);
        op_a[2] = 8'd250; op_b[2] = 8'd101; m_lat = 5; m_stale = 1'b1;
        run_job(4'b0100, 1'b0, 1'b0, 0);
        m_stale = 1'b0;

        // randomized jobs
        for (int it = 0; it < 24; it++) begin
            logic [3:0] mask;
            for (int i = 0; i < R; i++) begin
                op_a[i] = 8'($urandom_range(0, 255));
                op_b[i] = 8'($urandom_range(0, 255));
            end
            mask = 4'($urandom_range(1, 15));
            m_lat = $urandom_range(0, 16);
            m_stale = ($urandom_range(0, 3) == 0);
            run_job(mask, $urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 3));
            req_valid = '0;
        end
        m_stale = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
